buttons_res: RTL and testbench

- Elevator call-button register bank.
- Latches single-cycle presses of the in-cabin floor buttons and the hall up/down buttons into sticky "active request" flags.
- Flags stay set until the controller, on serving a floor, pulses the matching inactivate input.
- Sits between the raw button inputs and the elevator scheduling FSM; one instance per elevator.

---
 rtl/buttons_res.sv | 60 ++++++
 tb/tb_buttons_res.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/buttons_res.sv
// Elevator call-button register bank: sticky request flags for cabin, hall-up and hall-down buttons.
// Latency: one clk from a press or an inactivate pulse to the registered output.
// No backpressure: every input is sampled on each rising edge, and clear wins over press.
module buttons_res #(
    parameter int BUTTONS_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BUTTONS_WIDTH-1:0] btn_in,
    input  logic [BUTTONS_WIDTH-2:0] btn_up_out,
    input  logic [BUTTONS_WIDTH-1:1] btn_down_out,
    input  logic [BUTTONS_WIDTH-1:0] inactivate_in_levels,
    input  logic [BUTTONS_WIDTH-2:0] inactivate_out_up_levels,
    input  logic [BUTTONS_WIDTH-1:1] inactivate_out_down_levels,
    output logic [BUTTONS_WIDTH-1:0] active_in_levels,
    output logic [BUTTONS_WIDTH-2:0] active_out_up_levels,
    output logic [BUTTONS_WIDTH-1:1] active_out_down_levels
);

    localparam int N = BUTTONS_WIDTH;

    // Next-state values. A press ORs into the held flag. The served-floor
    // clear then masks the result, so a press that arrives in the same cycle
    // as its clear is absorbed.
    logic [N-1:0] next_in;
    logic [N-2:0] next_up;
    logic [N-1:1] next_down;

    assign next_in   = (active_in_levels       | btn_in)       & ~inactivate_in_levels;
    assign next_up   = (active_out_up_levels   | btn_up_out)   & ~inactivate_out_up_levels;
    assign next_down = (active_out_down_levels | btn_down_out) & ~inactivate_out_down_levels;

    // Cabin floor-select flags. Reset overrides any press or clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_in_levels <= '0;
        end else begin
            active_in_levels <= next_in;
        end
    end

    // Hall-up flags. The top floor has no up button, so it has no flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_out_up_levels <= '0;
        end else begin
            active_out_up_levels <= next_up;
        end
    end

    // Hall-down flags. Floor 0 has no down button, so it has no flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_out_down_levels <= '0;
        end else begin
            active_out_down_levels <= next_down;
        end
    end

endmodule

// File: tb/tb_buttons_res.sv
// Scoreboarded bench for buttons_res: a per-floor request model predicts the flags.
// Stimulus pushes the prediction after each edge; a negedge monitor pops it and compares.
// The bench also checks the directed test-plan sequences against spot constants.
module tb_buttons_res;

    localparam int N = 8;

    typedef struct {
        logic [N-1:0] v_in;
        logic [N-2:0] v_up;
        logic [N-1:1] v_dn;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] btn_in;
    logic [N-2:0] btn_up_out;
    logic [N-1:1] btn_down_out;
    logic [N-1:0] inactivate_in_levels;
    logic [N-2:0] inactivate_out_up_levels;
    logic [N-1:1] inactivate_out_down_levels;
    logic [N-1:0] active_in_levels;
    logic [N-2:0] active_out_up_levels;
    logic [N-1:1] active_out_down_levels;

    int checks   = 0;
    int failures = 0;

    exp_t exp_q[$];

    // Model state: one request bit per existing button.
    bit req_in[N];
    bit req_up[N];
    bit req_dn[N];

    buttons_res #(.BUTTONS_WIDTH(N)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .btn_in                     (btn_in),
        .btn_up_out                 (btn_up_out),
        .btn_down_out               (btn_down_out),
        .inactivate_in_levels       (inactivate_in_levels),
        .inactivate_out_up_levels   (inactivate_out_up_levels),
        .inactivate_out_down_levels (inactivate_out_down_levels),
        .active_in_levels           (active_in_levels),
        .active_out_up_levels       (active_out_up_levels),
        .active_out_down_levels     (active_out_down_levels)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%02h required=0x%02h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: outputs are valid every cycle, so one prediction is consumed per negedge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_in",   active_in_levels,                 e.v_in);
            chk("sb_up",   {1'b0, active_out_up_levels},     {1'b0, e.v_up});
            chk("sb_down", {1'b0, active_out_down_levels},   {1'b0, e.v_dn});
        end
    end

    // Drives one cycle of inputs and waits for the edge. It then advances the
    // request model and queues the predicted outputs.
    task automatic step(input logic rst,
                        input logic [N-1:0] b_in, input logic [N-2:0] b_up, input logic [N-1:1] b_dn,
                        input logic [N-1:0] c_in, input logic [N-2:0] c_up, input logic [N-1:1] c_dn);
        exp_t e;
        reset = rst;
        btn_in = b_in;
        btn_up_out = b_up;
        btn_down_out = b_dn;
        inactivate_in_levels = c_in;
        inactivate_out_up_levels = c_up;
        inactivate_out_down_levels = c_dn;
        @(posedge clk);
        for (int f = 0; f < N; f++) begin
            if (rst)          req_in[f] = 0;
            else if (c_in[f]) req_in[f] = 0;   // floor served: any press is absorbed
            else if (b_in[f]) req_in[f] = 1;
        end
        for (int f = 0; f <= N - 2; f++) begin
            if (rst)          req_up[f] = 0;
            else if (c_up[f]) req_up[f] = 0;
            else if (b_up[f]) req_up[f] = 1;
        end
        for (int f = 1; f <= N - 1; f++) begin
            if (rst)          req_dn[f] = 0;
            else if (c_dn[f]) req_dn[f] = 0;
            else if (b_dn[f]) req_dn[f] = 1;
        end
        for (int f = 0; f < N; f++) e.v_in[f] = req_in[f];
        for (int f = 0; f <= N - 2; f++) e.v_up[f] = req_up[f];
        for (int f = 1; f <= N - 1; f++) e.v_dn[f] = req_dn[f];
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle_reset();
        step(1'b1, N'($urandom), (N-1)'($urandom), (N-1)'($urandom),
             N'($urandom), (N-1)'($urandom), (N-1)'($urandom));
    endtask

    initial begin
        int v;
        // Reset with random inputs, which must be ignored.
        idle_reset();
        @(negedge clk);
        chk("reset_in", active_in_levels, 8'h00);
        chk("reset_up", {1'b0, active_out_up_levels}, 8'h00);
        chk("reset_down", {1'b0, active_out_down_levels}, 8'h00);

        // Cabin walk: two laps of single-cycle presses.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                step(1'b0, N'(1 << i), '0, '0, '0, '0, '0);
                @(negedge clk);
                v = (r == 0) ? ((1 << (i + 1)) - 1) : 8'hFF;
                chk("cabin_walk", active_in_levels, 8'(v));
            end
        end

        // Cabin clear chase: press k while clearing k-2.
        idle_reset();
        for (int k = 2; k <= 9; k++) begin
            step(1'b0, N'(1 << (k % N)), '0, '0, N'(1 << ((k - 2) % N)), '0, '0);
            @(negedge clk);
            v = (k == 2) ? 8'h04 : ((1 << (k % N)) | (1 << ((k - 1) % N)));
            chk("clear_chase", active_in_levels, 8'(v));
        end

        // Hall up: fill the flags, then clear them one per cycle.
        idle_reset();
        for (int i = 0; i <= N - 2; i++) step(1'b0, '0, (N-1)'(1 << i), '0, '0, '0, '0);
        @(negedge clk);
        chk("up_full", {1'b0, active_out_up_levels}, 8'h7F);
        for (int i = 0; i <= N - 2; i++) begin
            step(1'b0, '0, '0, '0, '0, (N-1)'(1 << i), '0);
            @(negedge clk);
            chk("up_drain", {1'b0, active_out_up_levels}, 8'(8'h7F & ~((1 << (i + 1)) - 1)));
        end
        chk("up_keeps_in", active_in_levels, 8'h00);
        chk("up_keeps_down", {1'b0, active_out_down_levels}, 8'h00);

        // Hall down: same sequence on floors 1..7.
        for (int i = 1; i <= N - 1; i++) step(1'b0, '0, '0, (N-1)'(1 << (i - 1)), '0, '0, '0);
        @(negedge clk);
        chk("down_full", {1'b0, active_out_down_levels}, 8'h7F);
        for (int i = 1; i <= N - 1; i++) begin
            step(1'b0, '0, '0, '0, '0, '0, (N-1)'(1 << (i - 1)));
        end
        @(negedge clk);
        chk("down_drained", {1'b0, active_out_down_levels}, 8'h00);
        chk("down_keeps_up", {1'b0, active_out_up_levels}, 8'h00);

        // Collision: a press on a set flag while that flag is cleared.
        step(1'b0, 8'h08, '0, '0, '0, '0, '0);
        step(1'b0, 8'h08, '0, '0, 8'h08, '0, '0);
        @(negedge clk);
        chk("collision", active_in_levels, 8'h00);

        // Mid-operation reset with the buttons held.
        step(1'b0, 8'hA5, 7'h2A, 7'h54, '0, '0, '0);
        @(negedge clk);
        chk("held_in", active_in_levels, 8'hA5);
        step(1'b1, 8'hA5, 7'h2A, 7'h54, '0, '0, '0);
        @(negedge clk);
        chk("midreset_in", active_in_levels, 8'h00);
        chk("midreset_up", {1'b0, active_out_up_levels}, 8'h00);
        chk("midreset_down", {1'b0, active_out_down_levels}, 8'h00);
        step(1'b0, 8'hA5, 7'h2A, 7'h54, '0, '0, '0);
        @(negedge clk);
        chk("reset_rearm_in", active_in_levels, 8'hA5);
        chk("reset_rearm_up", {1'b0, active_out_up_levels}, 8'h2A);
        chk("reset_rearm_down", {1'b0, active_out_down_levels}, 8'h54);

        // Random traffic: dense presses, sparse clears and rare resets.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(31) == 0),
                 N'($urandom & $urandom), (N-1)'($urandom & $urandom), (N-1)'($urandom & $urandom),
                 N'($urandom & $urandom & $urandom), (N-1)'($urandom & $urandom & $urandom),
                 (N-1)'($urandom & $urandom & $urandom));
        end

        // Let the monitor drain the queue, within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
